// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment table, FSM states, select helpers.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] BLANK = 7'b1111111;

    // Active-low abcdefg patterns, indexed by hex nibble.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_HELD
    } state_t;

    // True when exactly one anode line is driven low.
    function automatic logic is_single_select(input logic [NUM_DIGITS-1:0] anode);
        logic [NUM_DIGITS-1:0] sel;
        sel = ~anode;
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] anode);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!anode[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_pattern_dec.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
module sevenseg_pattern_dec
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        o_legal  = 1'b0;
        o_nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_TABLE[i]) begin
                o_legal  = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Decodes a scanned 8-digit seven-segment bus back into a 32-bit word.
// Optional macro SEVSEG_ERR_CNT_EN adds a saturating err_count output.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  anode,
    input  logic [6:0]  seg,
    output logic [31:0] value,
    output logic        frame_valid,
    output logic [7:0]  captured,
    output logic        digit_err
`ifdef SEVSEG_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [7:0] SETTLE_LIM = SETTLE_CYCLES[7:0];

    logic [7:0]  r_anode_sync [SYNC_STAGES];
    logic [6:0]  r_seg_sync   [SYNC_STAGES];

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [14:0] r_lat_sample;
    logic [31:0] r_shadow;
    logic [31:0] r_value;
    logic [7:0]  r_captured;
    logic        r_frame_valid;
    logic        r_digit_err;

    logic [7:0]  w_anode_s;
    logic [6:0]  w_seg_s;
    logic [14:0] w_sample;
    logic        w_valid_sel;
    logic        w_same;
    logic [2:0]  w_digit_idx;
    logic [4:0]  w_nib_lsb;
    logic [7:0]  w_digit_mask;
    logic        w_legal;
    logic [3:0]  w_nibble;
    logic [31:0] w_merged;
    logic        w_accept;
    logic        w_restart;

    // NOTE: the synchroniser stages are reset to blank so a stale select never leaks out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_anode_sync[i] <= '1;
                r_seg_sync[i]   <= BLANK;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage shift on the same edge.
            r_anode_sync[0] <= anode;
            r_seg_sync[0]   <= seg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_anode_sync[i] <= r_anode_sync[i-1];
                r_seg_sync[i]   <= r_seg_sync[i-1];
            end
        end
    end

    assign w_anode_s    = r_anode_sync[SYNC_STAGES-1];
    assign w_seg_s      = r_seg_sync[SYNC_STAGES-1];
    assign w_sample     = {w_anode_s, w_seg_s};
    assign w_valid_sel  = is_single_select(w_anode_s);
    assign w_same       = (w_sample == r_lat_sample);
    assign w_digit_idx  = low_index(w_anode_s);
    assign w_nib_lsb    = {w_digit_idx, 2'b00};
    assign w_digit_mask = 8'b1 << w_digit_idx;

    sevenseg_pattern_dec u_dec (
        .i_seg    (w_seg_s),
        .o_legal  (w_legal),
        .o_nibble (w_nibble)
    );

    always_comb begin
        w_merged = r_shadow;
        w_merged[w_nib_lsb +: 4] = w_nibble;
    end

    // A restart begins a fresh stability count; with a limit of 1 it accepts immediately.
    always_comb begin
        w_accept  = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_valid_sel) begin
                    w_restart = 1'b1;
                    w_accept  = (SETTLE_LIM == 8'd1);
                end
            end
            S_SETTLE: begin
                if (w_valid_sel) begin
                    if (w_same) begin
                        w_accept = ((r_cnt + 8'd1) == SETTLE_LIM);
                    end else begin
                        w_restart = 1'b1;
                        w_accept  = (SETTLE_LIM == 8'd1);
                    end
                end
            end
            S_HELD: begin
                if (w_valid_sel && !w_same) begin
                    w_restart = 1'b1;
                    w_accept  = (SETTLE_LIM == 8'd1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_WAIT;
            r_cnt         <= '0;
            r_lat_sample  <= '1;
            r_shadow      <= '0;
            r_value       <= '0;
            r_captured    <= '0;
            r_frame_valid <= 1'b0;
            r_digit_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_digit_err   <= 1'b0;
            if (!w_valid_sel) begin
                r_state <= S_WAIT;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_state      <= S_HELD;
                r_cnt        <= SETTLE_LIM;
                r_lat_sample <= w_sample;
                if (w_legal) begin
                    r_shadow[w_nib_lsb +: 4] <= w_nibble;
                    if ((r_captured | w_digit_mask) == 8'hFF) begin
                        r_value       <= w_merged;
                        r_frame_valid <= 1'b1;
                        r_captured    <= '0;
                    end else begin
                        r_captured <= r_captured | w_digit_mask;
                    end
                end else begin
                    r_digit_err <= 1'b1;
                end
            end else if (w_restart) begin
                r_state      <= S_SETTLE;
                r_cnt        <= 8'd1;
                r_lat_sample <= w_sample;
            end else if (r_state == S_SETTLE) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

`ifdef SEVSEG_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Counts on the edge that raises digit_err, so both are visible together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_count <= '0;
        end else if (w_valid_sel && w_accept && !w_legal && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign value       = r_value;
    assign frame_valid = r_frame_valid;
    assign captured    = r_captured;
    assign digit_err   = r_digit_err;

endmodule
